// File: rtl/line_write_combiner.sv
// Write-combining buffer: merges 16-bit byte-enabled word writes into one staged
// 128-bit line and issues it as a single masked line write to the memory side.
module line_write_combiner #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [15:0]  wr_addr,
  input  logic [15:0]  wr_data,
  input  logic [1:0]   wr_byte_en,
  input  logic         flush,
  output logic         empty,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [127:0] mem_wdata,
  output logic [15:0]  mem_byte_en,
  input  logic         mem_resp,
  output logic [1:0]   dbg_state
);

  // Handshake: a write transfers on a rising clk edge where wr_valid && wr_ready;
  // wr_ready never depends on wr_valid. mem_write is held until a one-cycle mem_resp.

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TO_V = IW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [11:0]     tag_q, tag_d;
  logic [127:0]    line_q, line_d;
  logic [15:0]     mask_q, mask_d;
  logic [IW-1:0]   idle_q, idle_d;

  logic            tag_match;
  logic            accept;
  logic            timeout_hit;
  logic [2:0]      offset;
  logic [127:0]    merge_line;
  logic [15:0]     merge_mask;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = wr_addr[0];
  assign tag_match   = (wr_addr[15:4] == tag_q);
  assign offset      = wr_addr[3:1];
  assign timeout_hit = (TIMEOUT != 0) && (idle_q == TO_V);

  always_comb begin
    wr_ready = 1'b0;
    case (state_q)
      S_EMPTY:   wr_ready = 1'b1;
      S_COLLECT: wr_ready = tag_match && !flush;
      default:   wr_ready = 1'b0;
    endcase
  end

  assign accept = wr_valid && wr_ready;

  // A new line starts from a cleared base; otherwise merge onto the staged line.
  always_comb begin
    merge_line = (state_q == S_EMPTY) ? 128'd0 : line_q;
    merge_mask = (state_q == S_EMPTY) ? 16'd0  : mask_q;
    for (int i = 0; i < 8; i++) begin
      if (offset == 3'(i)) begin
        if (wr_byte_en[0]) begin
          merge_line[16*i +: 8]   = wr_data[7:0];
          merge_mask[2*i]         = 1'b1;
        end
        if (wr_byte_en[1]) begin
          merge_line[16*i+8 +: 8] = wr_data[15:8];
          merge_mask[2*i+1]       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    line_d  = line_q;
    mask_d  = mask_q;
    idle_d  = idle_q;
    case (state_q)
      S_EMPTY: begin
        if (accept && (wr_byte_en != 2'b00)) begin
          tag_d   = wr_addr[15:4];
          line_d  = merge_line;
          mask_d  = merge_mask;
          idle_d  = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          line_d = merge_line;
          mask_d = merge_mask;
          idle_d = '0;
        end else if (idle_q != TO_V) begin
          idle_d = idle_q + 1'b1;
        end
        if (flush || (wr_valid && !tag_match) || (mask_d == 16'hFFFF) || timeout_hit) begin
          state_d = S_DRAIN;
          idle_d  = '0;
        end
      end
      S_DRAIN: begin
        if (mem_resp) begin
          mask_d  = 16'd0;
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      tag_q   <= 12'd0;
      line_q  <= 128'd0;
      mask_q  <= 16'd0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      mask_q  <= mask_d;
      idle_q  <= idle_d;
    end
  end

  assign empty       = (state_q == S_EMPTY);
  assign mem_write   = (state_q == S_DRAIN);
  assign mem_address = {tag_q, 4'b0000};
  assign mem_wdata   = line_q;
  assign mem_byte_en = mask_q;
  assign dbg_state   = state_q;

endmodule
